// File: rtl/row_drain_sequencer.sv
// row_drain_sequencer
//
// Captures one completed systolic-array row and presents its lanes one at a
// time to the downstream select_mux. The row is held stable on row_hold, which
// feeds select_mux.in2, and sel steps through the lanes. While idle, sel parks
// at array_size, so the mux forwards its in1 passthrough input.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. valid never depends on ready. Once valid is
// raised, it and its payload hold until the transfer completes.
//
// Optional feature: define ROW_DRAIN_BACK2BACK_EN to accept the next row on
// the same edge that the last beat of the current row is taken. This gives
// zero-bubble rows. When it is undefined, one IDLE cycle separates rows.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   row_valid  upstream row available
//   row_ready  sequencer can accept a row (decoded from state)
//   row_data   row payload; lane k at bits [k*data_size +: data_size]
//   row_len    valid lanes in the row; 0 or oversize means array_size
//   row_hold   latched row, to select_mux.in2
//   sel        lane index, to select_mux.sel (array_size when idle)
//   out_valid  current beat valid at the mux output
//   out_ready  downstream accepts the beat
//   out_last   current beat is the final lane of the row (decoded)
//   busy       FSM is in DRAIN (exposes FSM state)
//   row_count  completed rows, wraps modulo 2^dimdata_size
module row_drain_sequencer #(
    parameter int array_size   = 9,
    parameter int data_size    = 16,
    parameter int dimdata_size = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             row_valid,
    output logic                             row_ready,
    input  logic [data_size*array_size-1:0]  row_data,
    input  logic [dimdata_size-1:0]          row_len,
    output logic [data_size*array_size-1:0]  row_hold,
    output logic [dimdata_size-1:0]          sel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic [dimdata_size-1:0]          row_count
);

    localparam logic [dimdata_size-1:0] PARK = dimdata_size'(array_size);
    localparam logic [dimdata_size-1:0] ONE  = dimdata_size'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state;
    logic [dimdata_size-1:0] len_eff;
    logic [dimdata_size-1:0] len_next;
    logic                    accept;
    logic                    beat_done;

    // A zero or oversize length drains the full row.
    always_comb begin
        len_next = PARK;
        if ((row_len != '0) && (row_len <= PARK)) begin
            len_next = row_len;
        end
    end

    assign busy      = (state == DRAIN);
    // len_eff is always 1..array_size, so len_eff-1 cannot underflow.
    assign out_last  = (state == DRAIN) && (sel == (len_eff - ONE));
    assign beat_done = out_valid & out_ready;

`ifdef ROW_DRAIN_BACK2BACK_EN
    assign row_ready = (state == IDLE) || (out_last && out_ready);
`else
    assign row_ready = (state == IDLE);
`endif

    assign accept = row_valid & row_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= PARK;
            row_hold  <= '0;
            len_eff   <= PARK;
            row_count <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        row_hold  <= row_data;
                        len_eff   <= len_next;
                        sel       <= '0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat_done) begin
                        if (out_last) begin
                            row_count <= row_count + ONE;
                            // accept can only be high here when the
                            // back-to-back path is built in.
                            if (accept) begin
                                row_hold <= row_data;
                                len_eff  <= len_next;
                                sel      <= '0;
                            end else begin
                                sel       <= PARK;
                                out_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            sel <= sel + ONE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    sel       <= PARK;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
